// File: rtl/ascon_round_ctrl.sv
// Ascon permutation round controller: sequences p^r constant additions around an
// external substitution/diffusion datapath, one round per clock.
module ascon_round_ctrl #(
    parameter int N          = 64,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x0_in,
    input  logic [N-1:0] x1_in,
    input  logic [N-1:0] x2_in,
    input  logic [N-1:0] x3_in,
    input  logic [N-1:0] x4_in,
    input  logic [3:0]   rounds,
    output logic [N-1:0] p0,
    output logic [N-1:0] p1,
    output logic [N-1:0] p2,
    output logic [N-1:0] p3,
    output logic [N-1:0] p4,
    input  logic [N-1:0] t0,
    input  logic [N-1:0] t1,
    input  logic [N-1:0] t2,
    input  logic [N-1:0] t3,
    input  logic [N-1:0] t4,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x0_out,
    output logic [N-1:0] x1_out,
    output logic [N-1:0] x2_out,
    output logic [N-1:0] x3_out,
    output logic [N-1:0] x4_out,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] TABLE_SIZE = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_IDX   = 4'(MAX_ROUNDS - 1);

    state_t       r_state;
    logic [N-1:0] r_x0, r_x1, r_x2, r_x3, r_x4;
    logic [3:0]   r_round_idx;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [3:0]   w_rounds_clamped;
    logic [7:0]   w_round_const;
    logic [7:0]   w_const_add;

    assign w_rounds_clamped = (rounds > 4'd12) ? 4'd12 : rounds;

    // Round constants for the tail of the 12-round schedule; a shorter
    // permutation simply starts further into the table.
    always_comb begin
        w_round_const = 8'h00;
        case (r_round_idx)
            4'd0:    w_round_const = 8'hf0;
            4'd1:    w_round_const = 8'he1;
            4'd2:    w_round_const = 8'hd2;
            4'd3:    w_round_const = 8'hc3;
            4'd4:    w_round_const = 8'hb4;
            4'd5:    w_round_const = 8'ha5;
            4'd6:    w_round_const = 8'h96;
            4'd7:    w_round_const = 8'h87;
            4'd8:    w_round_const = 8'h78;
            4'd9:    w_round_const = 8'h69;
            4'd10:   w_round_const = 8'h5a;
            4'd11:   w_round_const = 8'h4b;
            default: w_round_const = 8'h00;
        endcase
    end

    assign w_const_add = (r_state == RUN) ? w_round_const : 8'h00;

    assign p0 = r_x0;
    assign p1 = r_x1;
    assign p2 = r_x2 ^ {{(N-8){1'b0}}, w_const_add};
    assign p3 = r_x3;
    assign p4 = r_x4;

    assign x0_out    = r_x0;
    assign x1_out    = r_x1;
    assign x2_out    = r_x2;
    assign x3_out    = r_x3;
    assign x4_out    = r_x4;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign round_idx = r_round_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_x4        <= '0;
            r_round_idx <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x0        <= x0_in;
                        r_x1        <= x1_in;
                        r_x2        <= x2_in;
                        r_x3        <= x3_in;
                        r_x4        <= x4_in;
                        r_round_idx <= TABLE_SIZE - w_rounds_clamped;
                        r_in_ready  <= 1'b0;
                        if (w_rounds_clamped == 4'd0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_x0        <= t0;
                    r_x1        <= t1;
                    r_x2        <= t2;
                    r_x3        <= t3;
                    r_x4        <= t4;
                    r_round_idx <= r_round_idx + 4'd1;
                    if (r_round_idx == LAST_IDX) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Output is held until consumed; no reload in the same cycle.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: drives vectors through either an identity loopback
// or a bench-side Ascon substitution/diffusion layer and scoreboards the results.
module tb_ascon_round_ctrl;

    typedef logic [4:0][63:0] st_t;

    typedef struct {
        logic       mode;
        logic [3:0] rounds;
        st_t        stateIn;
        int         hold;
        st_t        expOut;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] x0_in, x1_in, x2_in, x3_in, x4_in;
    logic [3:0]  rounds;
    logic [63:0] p0, p1, p2, p3, p4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] x0_out, x1_out, x2_out, x3_out, x4_out;
    logic        busy;
    logic [3:0]  round_idx;
    logic        loopMode;

    int  errCount = 0;
    int  checkCount = 0;
    st_t expQ[$];
    st_t pState, tState, outState;

    ascon_round_ctrl #(.N(64), .MAX_ROUNDS(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0_in(x0_in), .x1_in(x1_in), .x2_in(x2_in), .x3_in(x3_in), .x4_in(x4_in),
        .rounds(rounds),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_out(x0_out), .x1_out(x1_out), .x2_out(x2_out), .x3_out(x3_out), .x4_out(x4_out),
        .busy(busy), .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon round minus the constant addition: substitution then diffusion.
    function automatic st_t layer(input st_t s);
        logic [63:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
        st_t r;
        a0 = s[0] ^ s[4]; a4 = s[4] ^ s[3]; a2 = s[2] ^ s[1]; a1 = s[1]; a3 = s[3];
        b0 = ~a0 & a1; b1 = ~a1 & a2; b2 = ~a2 & a3; b3 = ~a3 & a4; b4 = ~a4 & a0;
        a0 = a0 ^ b1; a1 = a1 ^ b2; a2 = a2 ^ b3; a3 = a3 ^ b4; a4 = a4 ^ b0;
        a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
        r[0] = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        r[1] = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        r[2] = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        r[3] = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        r[4] = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
        return r;
    endfunction

    function automatic logic [7:0] rc(input int i);
        logic [3:0] hi, lo;
        hi = 4'(15 - i);
        lo = 4'(i);
        return {hi, lo};
    endfunction

    function automatic st_t permute(input st_t s, input logic mode, input int nr);
        int r;
        st_t v;
        v = s;
        r = (nr > 12) ? 12 : nr;
        for (int i = 12 - r; i < 12; i++) begin
            v[2][7:0] = v[2][7:0] ^ rc(i);
            if (mode) v = layer(v);
        end
        return v;
    endfunction

    function automatic st_t randState();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    always_comb begin
        pState   = {p4, p3, p2, p1, p0};
        tState   = loopMode ? layer(pState) : pState;
        outState = {x4_out, x3_out, x2_out, x1_out, x0_out};
    end
    assign t0 = tState[0];
    assign t1 = tState[1];
    assign t2 = tState[2];
    assign t3 = tState[3];
    assign t4 = tState[4];

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveState(input st_t s);
        x0_in = s[0]; x1_in = s[1]; x2_in = s[2]; x3_in = s[3]; x4_in = s[4];
    endtask

    task automatic applyStimulus(input vec_t v);
        int r, expLat, cycles;
        r = (v.rounds > 4'd12) ? 12 : int'(v.rounds);
        expLat = (r == 0) ? 1 : r + 1;
        @(negedge clk);
        checkOutput("in_ready_idle", in_ready, 1);
        loopMode = v.mode;
        in_valid = 1'b1;
        rounds   = v.rounds;
        driveState(v.stateIn);
        expQ.push_back(v.expOut);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                // Junk presented while busy must be ignored.
                driveState(randState());
                rounds = 4'($urandom_range(0, 15));
                if (r > 0) begin
                    checkOutput("round_idx_start", round_idx, 12 - r);
                    checkOutput("busy_run", busy, 1);
                    checkOutput("in_ready_run", in_ready, 0);
                    checkOutput("p2_first_run", p2, v.stateIn[2] ^ {56'b0, rc(12 - r)});
                end
            end
        end while (!out_valid && cycles < 40);
        checkOutput("latency", cycles, expLat);
        for (int h = 0; h < v.hold; h++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_state", outState, v.expOut);
            checkOutput("hold_p2", p2, v.expOut[2]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            checkOutput("x_out", outState, expQ.pop_front());
        end
        checkOutput("done_busy", busy, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("after_valid", out_valid, 0);
        checkOutput("after_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[8];
        st_t  zero, a;
        int   cycles;

        zero = '0;
        vecs[0] = '{mode: 1'b0, rounds: 4'd12, stateIn: zero, hold: 0, expOut: zero};
        vecs[1] = '{mode: 1'b0, rounds: 4'd6,  stateIn: zero, hold: 0, expOut: zero};
        vecs[1].expOut[2] = 64'h11;
        vecs[2] = '{mode: 1'b0, rounds: 4'd1,  stateIn: zero, hold: 0, expOut: zero};
        vecs[2].expOut[2] = 64'h4b;
        a = randState();
        vecs[3] = '{mode: 1'b0, rounds: 4'd0,  stateIn: a, hold: 5, expOut: a};
        for (int i = 4; i < 8; i++) begin
            vecs[i].mode    = 1'b1;
            vecs[i].stateIn = randState();
            vecs[i].hold    = (i == 5) ? 5 : 1;
        end
        vecs[4].rounds = 4'd6;
        vecs[5].rounds = 4'd8;
        vecs[6].rounds = 4'd12;
        vecs[7].rounds = 4'd15;
        for (int i = 4; i < 8; i++)
            vecs[i].expOut = permute(vecs[i].stateIn, 1'b1, int'(vecs[i].rounds));

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rounds = 4'd0;
        loopMode = 1'b0;
        driveState(zero);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_round_idx", round_idx, 0);
        checkOutput("reset_state", outState, zero);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);

        $display("[TB] running %0d table vectors", 8);
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Abort a 12-round permutation mid-flight with reset.
        @(negedge clk);
        in_valid = 1'b1;
        rounds   = 4'd12;
        loopMode = 1'b1;
        driveState(randState());
        expQ.push_back(zero);
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (round_idx != 4'd7 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("abort_reach_idx7", round_idx, 7);
        #2;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_round_idx", round_idx, 0);
        checkOutput("abort_state", outState, zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_no_valid", out_valid, 0);
        vecs[0].mode    = 1'b1;
        vecs[0].rounds  = 4'd8;
        vecs[0].stateIn = randState();
        vecs[0].hold    = 2;
        vecs[0].expOut  = permute(vecs[0].stateIn, 1'b1, 8);
        applyStimulus(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
